gclkdiv: RTL and testbench

Programmable, glitch-free integer clock divider that generates the divided clock driving the `A` input of the global clock buffer (`gclkbuff`). It counts the fabric clock and produces a registered, runt-free divided clock `Q` with a one-cycle rising-edge tick. The divisor can be changed at run time through a request/acknowledge handshake, and the new value is applied only on a period boundary. Start and stop requests never truncate a period.

---
 rtl/gclkdiv_pkg.sv | 17 +
 rtl/gclkdiv_cnt.sv | 53 +++++
 rtl/gclkdiv.sv | 112 +++++++++++
 tb/tb_gclkdiv.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/gclkdiv_pkg.sv
// ------------------------------------------------------------------
// gclkdiv_pkg: state encoding and divisor constants for gclkdiv. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package gclkdiv_pkg;

  localparam logic [1:0] ST_STOP  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_DRAIN = 2'b10;

  localparam int DIV_MIN = 2;
  localparam int DIV_RST = 2;

endpackage

`default_nettype wire

// File: rtl/gclkdiv_cnt.sv
// ------------------------------------------------------------------
// gclkdiv_cnt: phase counter with wrap, divisor clamp, high-phase compare. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module gclkdiv_cnt
  import gclkdiv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             C,
  input  logic             R,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] cnt,
  output logic             last,
  output logic             q_next
);

  logic [WIDTH-1:0] w_n;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH:0]   w_half;

  always_comb begin
    w_n    = (n < WIDTH'(DIV_MIN)) ? WIDTH'(DIV_MIN) : n;
    w_half = ({1'b0, w_n} + (WIDTH + 1)'(1)) >> 1;
    last   = (cnt == (w_n - WIDTH'(1)));
  end

  always_comb begin
    w_cnt_nxt = cnt;
    if (clear) begin
      w_cnt_nxt = '0;
    end else if (en) begin
      w_cnt_nxt = last ? '0 : (cnt + WIDTH'(1));
    end
  end

  // High for the first ceil(N/2) counts of each period
  assign q_next = ({1'b0, w_cnt_nxt} < w_half);

  always_ff @(posedge C) begin
    if (!R) begin
      cnt <= '0;
    end else begin
      cnt <= w_cnt_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/gclkdiv.sv
// ------------------------------------------------------------------
// gclkdiv: glitch-free programmable integer clock divider for gclkbuff.A. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module gclkdiv
  import gclkdiv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             C,
  input  logic             R,
  input  logic             E,
  input  logic [WIDTH-1:0] DIV,
  input  logic             LD,
  output logic             ACK,
  output logic             Q,
  output logic             T,
  output logic             RUN
);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_div;
  logic             r_ack;
  logic             r_q;
  logic             r_t;
  logic             r_run;

  logic [WIDTH-1:0] w_cnt;
  logic             w_last;
  logic             w_q_next;
  logic             w_boundary;
  logic             w_load;
  logic             w_run_d;
  logic             w_q_d;
  logic             w_t_d;
  logic             w_unused;

  gclkdiv_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .C      (C),
    .R      (R),
    .clear  (r_state == ST_STOP),
    .en     (r_state != ST_STOP),
    .n      (r_div),
    .cnt    (w_cnt),
    .last   (w_last),
    .q_next (w_q_next)
  );

  // Phase count is exported for observation; the top only needs the flags
  assign w_unused = ^w_cnt;

  always_ff @(posedge C) begin
    if (!R) begin
      r_state <= ST_STOP;
      r_div   <= WIDTH'(DIV_RST);
      r_ack   <= 1'b0;
      r_q     <= 1'b0;
      r_t     <= 1'b0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_div <= DIV;
      end
      r_ack <= w_load;
      r_q   <= w_q_d;
      r_t   <= w_t_d;
      r_run <= w_run_d;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_STOP:  w_state_nxt = E ? ST_RUN : ST_STOP;
      ST_RUN: begin
        if (!E) begin
          w_state_nxt = w_last ? ST_STOP : ST_DRAIN;
        end
      end
      // Re-enable mid-drain resumes without touching the phase
      ST_DRAIN: begin
        if (E) begin
          w_state_nxt = ST_RUN;
        end else if (w_last) begin
          w_state_nxt = ST_STOP;
        end
      end
      default:  w_state_nxt = ST_STOP;
    endcase
  end

  always_comb begin
    w_boundary = (r_state == ST_STOP) || w_last;
    w_load     = LD && !r_ack && w_boundary;
    w_run_d    = (w_state_nxt != ST_STOP);
    w_q_d      = w_run_d && w_q_next;
    w_t_d      = w_run_d && w_boundary;
  end

  assign ACK = r_ack;
  assign Q   = r_q;
  assign T   = r_t;
  assign RUN = r_run;

endmodule

`default_nettype wire

// File: tb/tb_gclkdiv.sv
// ------------------------------------------------------------------
// tb_gclkdiv: directed-vector bench for gclkdiv, outputs packed as {Q,T,RUN,ACK}. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_gclkdiv;

  localparam int WIDTH = 8;

  logic             C = 1'b0;
  logic             R;
  logic             E;
  logic [WIDTH-1:0] DIV;
  logic             LD;
  logic             ACK;
  logic             Q;
  logic             T;
  logic             RUN;

  int vectors     = 0;
  int miscompares = 0;

  gclkdiv #(
    .WIDTH (WIDTH)
  ) dut (
    .C   (C),
    .R   (R),
    .E   (E),
    .DIV (DIV),
    .LD  (LD),
    .ACK (ACK),
    .Q   (Q),
    .T   (T),
    .RUN (RUN)
  );

  always #5 C = ~C;

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic expect_o(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {Q, T, RUN, ACK};
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed QTRA=%b expected QTRA=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] exp);
    tick();
    expect_o(tag, exp);
  endtask

  initial begin
    logic [WIDTH-1:0] small_div [2];
    logic [3:0]       e;
    small_div[0] = 8'd0;
    small_div[1] = 8'd1;

    R = 1'b0; E = 1'b0; LD = 1'b0; DIV = '0;
    tick();
    tick();
    expect_o("reset", 4'b0000);
    R = 1'b1;
    step("idle", 4'b0000);

    // Default divisor 2 after reset
    E = 1'b1;
    step("start", 4'b1110);
    step("n2_lo", 4'b0010);
    step("n2_hi", 4'b1110);
    step("n2_lo2", 4'b0010);

    // Load 5 while running, at the cnt=1 boundary
    LD = 1'b1; DIV = 8'd5;
    step("ld5_ack", 4'b1111);
    step("ld5_no_reack", 4'b1010);
    LD = 1'b0;
    step("n5_c2", 4'b1010);
    step("n5_c3", 4'b0010);
    step("n5_c4", 4'b0010);
    step("n5_wrap", 4'b1110);

    // Drop E at cnt=1: finish period then stop
    step("dr_c1", 4'b1010);
    E = 1'b0;
    step("dr_c2", 4'b1010);
    step("dr_c3", 4'b0010);
    step("dr_c4", 4'b0010);
    step("dr_stop", 4'b0000);
    step("dr_stay", 4'b0000);

    // Drop at cnt=1, reassert at cnt=3: no gap
    E = 1'b1;
    step("re_start", 4'b1110);
    step("re_c1", 4'b1010);
    E = 1'b0;
    step("re_c2", 4'b1010);
    step("re_c3", 4'b0010);
    E = 1'b1;
    step("re_c4", 4'b0010);
    step("re_wrap", 4'b1110);
    step("re_p_c1", 4'b1010);
    step("re_p_c2", 4'b1010);
    step("re_p_c3", 4'b0010);
    step("re_p_c4", 4'b0010);
    step("re_p_wrap", 4'b1110);

    // Stop from cnt=0
    E = 1'b0;
    step("st_c1", 4'b1010);
    step("st_c2", 4'b1010);
    step("st_c3", 4'b0010);
    step("st_c4", 4'b0010);
    step("st_stop", 4'b0000);

    // DIV=0 and DIV=1 clamp to 2
    for (int k = 0; k < 2; k++) begin
      LD = 1'b1; DIV = small_div[k];
      step("small_ack", 4'b0001);
      step("small_no_reack", 4'b0000);
      LD = 1'b0;
      E = 1'b1;
      step("small_hi", 4'b1110);
      step("small_lo", 4'b0010);
      step("small_hi2", 4'b1110);
      E = 1'b0;
      step("small_drain", 4'b0010);
      step("small_stop", 4'b0000);
    end

    // DIV=255: 128 high, 127 low
    LD = 1'b1; DIV = 8'd255;
    step("d255_ack", 4'b0001);
    step("d255_no_reack", 4'b0000);
    LD = 1'b0;
    E = 1'b1;
    step("d255_c0", 4'b1110);
    for (int i = 1; i < 255; i++) begin
      tick();
      e = {(i < 128) ? 1'b1 : 1'b0, 3'b010};
      expect_o("d255_phase", e);
    end
    step("d255_wrap", 4'b1110);

    // Reset while running with a load pending
    R = 1'b0; E = 1'b0;
    step("rst_run", 4'b0000);
    R = 1'b1;
    LD = 1'b1; DIV = 8'd5;
    step("r5_ack", 4'b0001);
    step("r5_no_reack", 4'b0000);
    LD = 1'b0;
    E = 1'b1;
    step("r5_c0", 4'b1110);
    LD = 1'b1; DIV = 8'd7;
    step("r5_c1_pending", 4'b1010);
    R = 1'b0; LD = 1'b0;
    step("rst_pending", 4'b0000);
    R = 1'b1;
    step("post_rst_hi", 4'b1110);
    step("post_rst_lo", 4'b0010);
    step("post_rst_hi2", 4'b1110);
    step("post_rst_lo2", 4'b0010);

    // Boundary with E=0 and LD=1: load and stop together
    E = 1'b0; LD = 1'b1; DIV = 8'd3;
    step("ld_stop_ack", 4'b0001);
    LD = 1'b0;
    step("ld_stop_idle", 4'b0000);
    E = 1'b1;
    step("n3_c0", 4'b1110);
    step("n3_c1", 4'b1010);
    step("n3_c2", 4'b0010);
    step("n3_wrap", 4'b1110);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
